// File: rtl/beam_pkg.sv
// beam_pkg: shared types, widths and helpers for the beam scanner family.
package beam_pkg;
    localparam int BEAM_W = 6;
    localparam int ANG_W  = 8;
    localparam int CPLX_W = 32;

    typedef enum logic [2:0] {IDLE, FETCH, MAC, POWER, COMPARE, FINISH} state_t;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    function automatic int addr_w(input int beams, input int mics);
        return $clog2(beams * mics);
    endfunction

    function automatic int mic_w(input int mics);
        return (mics > 1) ? $clog2(mics) : 1;
    endfunction
endpackage

// File: rtl/beam_scanner_if.sv
// beam_scanner_if: spectrum input, coefficient ROM port and scan results of the beam scanner.
interface beam_scanner_if
    import beam_pkg::*;
#(
    parameter int NUM_MICS  = 4,
    parameter int NUM_BEAMS = 37,
    parameter int DATA_W    = 14,
    parameter int COEF_W    = 14,
    parameter int ACC_W     = 32
);
    localparam int ADDR_W = addr_w(NUM_BEAMS, NUM_MICS);
    localparam int PW     = 2 * ACC_W + 1;

    logic                           start;
    logic [NUM_MICS*2*DATA_W-1:0]   spec_q;
    logic [ADDR_W-1:0]              coef_addr;
    logic [2*COEF_W-1:0]            coef_q;
    logic [PW-1:0]                  pwr_thresh;
    logic                           busy;
    logic                           pwr_valid;
    logic [BEAM_W-1:0]              pwr_beam;
    logic [PW-1:0]                  pwr;
    logic                           done;
    logic [BEAM_W-1:0]              best_beam;
    logic [PW-1:0]                  best_pwr;
    logic signed [ANG_W-1:0]        doa;
    logic                           detect;

    modport slave (
        input  start, spec_q, coef_q, pwr_thresh,
        output coef_addr, busy, pwr_valid, pwr_beam, pwr, done,
               best_beam, best_pwr, doa, detect
    );

    modport master (
        output start, spec_q, coef_q, pwr_thresh,
        input  coef_addr, busy, pwr_valid, pwr_beam, pwr, done,
               best_beam, best_pwr, doa, detect
    );
endinterface

// File: rtl/cmplx_mac.sv
// cmplx_mac: signed complex product of a spectrum sample and a coefficient,
// sign-extended to accumulator width.
module cmplx_mac #(
    parameter int DATA_W = 14,
    parameter int COEF_W = 14,
    parameter int ACC_W  = 32
) (
    input  logic signed [DATA_W-1:0] sr_i,
    input  logic signed [DATA_W-1:0] si_i,
    input  logic signed [COEF_W-1:0] cr_i,
    input  logic signed [COEF_W-1:0] ci_i,
    output logic signed [ACC_W-1:0]  re_o,
    output logic signed [ACC_W-1:0]  im_o
);
    localparam int P_W = DATA_W + COEF_W;

    logic signed [P_W-1:0] rr, ii, ri, ir;

    assign rr   = P_W'(sr_i) * P_W'(cr_i);
    assign ii   = P_W'(si_i) * P_W'(ci_i);
    assign ri   = P_W'(sr_i) * P_W'(ci_i);
    assign ir   = P_W'(si_i) * P_W'(cr_i);
    assign re_o = ACC_W'(rr) - ACC_W'(ii);
    assign im_o = ACC_W'(ri) + ACC_W'(ir);
endmodule

// File: rtl/beam_scanner.sv
// beam_scanner: delay-and-sum scan over NUM_BEAMS steering vectors, streaming
// per-beam power and reporting the strongest beam, its angle and a detection flag.
module beam_scanner
    import beam_pkg::*;
#(
    parameter int NUM_MICS  = 4,
    parameter int NUM_BEAMS = 37,
    parameter int DATA_W    = 14,
    parameter int COEF_W    = 14,
    parameter int ACC_W     = 32,
    parameter int ANG_MIN   = -90,
    parameter int ANG_STEP  = 5
) (
    input  logic          clk,
    input  logic [3:0]    KEY,
    beam_scanner_if.slave bus
);
    localparam int ADDR_W = addr_w(NUM_BEAMS, NUM_MICS);
    localparam int MIC_W  = mic_w(NUM_MICS);
    localparam int SQ_W   = 2 * ACC_W;
    localparam int PW     = SQ_W + 1;

    state_t                   state_q;
    logic signed [DATA_W-1:0] spec_re_q [NUM_MICS];
    logic signed [DATA_W-1:0] spec_im_q [NUM_MICS];
    logic [BEAM_W-1:0]        beam_q, run_beam_q, pwr_beam_q, best_beam_q;
    logic [MIC_W-1:0]         mic_q;
    logic [ADDR_W-1:0]        coef_addr_q;
    logic signed [ACC_W-1:0]  acc_re_q, acc_im_q;
    logic [PW-1:0]            pwr_q, run_max_q, best_pwr_q;
    logic signed [ANG_W-1:0]  doa_q;
    logic                     busy_q, done_q, pwr_valid_q, detect_q;

    logic signed [ACC_W-1:0]  prod_re, prod_im;
    logic [SQ_W-1:0]          sq_re, sq_im;
    logic [PW-1:0]            pwr_d, max_d;
    logic [BEAM_W-1:0]        beam_d;
    logic                     unused_key;

    assign unused_key = &{1'b0, KEY[3:1]};

    cmplx_mac #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .sr_i(spec_re_q[mic_q]),
        .si_i(spec_im_q[mic_q]),
        .cr_i(bus.coef_q[2*COEF_W-1:COEF_W]),
        .ci_i(bus.coef_q[COEF_W-1:0]),
        .re_o(prod_re),
        .im_o(prod_im)
    );

    // Squares are non-negative, so zero-extending them into the sum cannot overflow.
    always_comb begin
        sq_re  = SQ_W'(acc_re_q) * SQ_W'(acc_re_q);
        sq_im  = SQ_W'(acc_im_q) * SQ_W'(acc_im_q);
        pwr_d  = PW'(sq_re) + PW'(sq_im);
        max_d  = (pwr_q > run_max_q) ? pwr_q : run_max_q;
        beam_d = (pwr_q > run_max_q) ? beam_q : run_beam_q;
    end

    always_ff @(posedge clk) begin
        if (!KEY[0]) begin
            state_q     <= IDLE;
            beam_q      <= '0;
            mic_q       <= '0;
            coef_addr_q <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            run_max_q   <= '0;
            run_beam_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pwr_valid_q <= 1'b0;
            pwr_q       <= '0;
            pwr_beam_q  <= '0;
            best_beam_q <= '0;
            best_pwr_q  <= '0;
            doa_q       <= ANG_W'(ANG_MIN);
            detect_q    <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            pwr_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    for (int m = 0; m < NUM_MICS; m++) begin
                        spec_re_q[m] <= bus.spec_q[m*2*DATA_W+DATA_W +: DATA_W];
                        spec_im_q[m] <= bus.spec_q[m*2*DATA_W +: DATA_W];
                    end
                    beam_q      <= '0;
                    mic_q       <= '0;
                    coef_addr_q <= '0;
                    acc_re_q    <= '0;
                    acc_im_q    <= '0;
                    run_max_q   <= '0;
                    run_beam_q  <= '0;
                    busy_q      <= 1'b1;
                    state_q     <= FETCH;
                end
                FETCH: state_q <= MAC;
                // Address is beam*NUM_MICS+mic, which simply advances by one per fetch.
                MAC: begin
                    acc_re_q <= acc_re_q + prod_re;
                    acc_im_q <= acc_im_q + prod_im;
                    if (mic_q == MIC_W'(NUM_MICS - 1)) begin
                        state_q <= POWER;
                    end else begin
                        mic_q       <= mic_q + MIC_W'(1);
                        coef_addr_q <= coef_addr_q + ADDR_W'(1);
                        state_q     <= FETCH;
                    end
                end
                POWER: begin
                    pwr_q       <= pwr_d;
                    pwr_beam_q  <= beam_q;
                    pwr_valid_q <= 1'b1;
                    state_q     <= COMPARE;
                end
                COMPARE: begin
                    run_max_q  <= max_d;
                    run_beam_q <= beam_d;
                    if (beam_q == BEAM_W'(NUM_BEAMS - 1)) begin
                        best_beam_q <= beam_d;
                        best_pwr_q  <= max_d;
                        doa_q       <= ANG_W'(ANG_MIN + ANG_STEP * int'(beam_d));
                        detect_q    <= max_d >= bus.pwr_thresh;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= FINISH;
                    end else begin
                        beam_q      <= beam_q + BEAM_W'(1);
                        mic_q       <= '0;
                        coef_addr_q <= coef_addr_q + ADDR_W'(1);
                        acc_re_q    <= '0;
                        acc_im_q    <= '0;
                        state_q     <= FETCH;
                    end
                end
                FINISH: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.coef_addr = coef_addr_q;
    assign bus.busy      = busy_q;
    assign bus.pwr_valid = pwr_valid_q;
    assign bus.pwr_beam  = pwr_beam_q;
    assign bus.pwr       = pwr_q;
    assign bus.done      = done_q;
    assign bus.best_beam = best_beam_q;
    assign bus.best_pwr  = best_pwr_q;
    assign bus.doa       = doa_q;
    assign bus.detect    = detect_q;
endmodule

// File: tb/tb_beam_scanner.sv
// tb_beam_scanner: scoreboard bench for beam_scanner with default parameters and a
// behavioural coefficient ROM.
module tb_beam_scanner;
    import beam_pkg::*;

    typedef struct {
        int          beam;
        logic [64:0] pwr;
    } exp_t;

    logic        clk = 1'b0;
    logic [3:0]  KEY = 4'h0;
    logic [27:0] rom [148];
    exp_t        sb [$];
    int          n_chk = 0;
    int          n_err = 0;

    beam_scanner_if bus ();

    beam_scanner dut (
        .clk(clk),
        .KEY(KEY),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.coef_q <= rom[bus.coef_addr];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (KEY[0] && bus.pwr_valid) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pwr_beam", bus.pwr_beam, e.beam);
                chk("pwr", bus.pwr, e.pwr);
            end
        end
    end

    task automatic check_reset();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pwr_valid", bus.pwr_valid, 0);
        chk("rst_detect", bus.detect, 0);
        chk("rst_best_beam", bus.best_beam, 0);
        chk("rst_best_pwr", bus.best_pwr, 0);
        chk("rst_pwr", bus.pwr, 0);
        chk("rst_pwr_beam", bus.pwr_beam, 0);
        chk("rst_coef_addr", bus.coef_addr, 0);
        chk("rst_doa", $unsigned(bus.doa), 8'hA6);
    endtask

    task automatic set_spec(input int m, input int re, input int im);
        bus.spec_q[m*28 +: 28] = {14'(re), 14'(im)};
    endtask

    task automatic fill_rom(input int re, input int im);
        for (int a = 0; a < 148; a++) rom[a] = {14'(re), 14'(im)};
    endtask

    task automatic scan(input int busy_at, input int abort_at);
        cplx_t             acc;
        logic signed [64:0] r65, i65, p;
        logic [64:0]       best_p;
        int                best_b, k, nd;
        logic signed [13:0] sr, si, cr, ci;
        logic [7:0]        exp_doa;
        best_p = '0;
        best_b = 0;
        nd     = 0;
        for (int b = 0; b < 37; b++) begin
            acc = '0;
            for (int m = 0; m < 4; m++) begin
                sr = bus.spec_q[m*28+14 +: 14];
                si = bus.spec_q[m*28 +: 14];
                cr = rom[b*4+m][27:14];
                ci = rom[b*4+m][13:0];
                acc.re = acc.re + int'(sr) * int'(cr) - int'(si) * int'(ci);
                acc.im = acc.im + int'(sr) * int'(ci) + int'(si) * int'(cr);
            end
            r65 = 65'(acc.re);
            i65 = 65'(acc.im);
            p = r65 * r65 + i65 * i65;
            sb.push_back('{b, p});
            if (p > best_p) begin
                best_p = p;
                best_b = b;
            end
        end
        @(negedge clk);
        bus.start = 1'b1;
        for (k = 1; k < 600; k++) begin
            @(negedge clk);
            bus.start = (k == busy_at);
            if (k == 1) chk("busy_rise", bus.busy, 1);
            if (k == abort_at) begin
                KEY[0] = 1'b0;
                @(negedge clk);
                KEY[0] = 1'b1;
                sb.delete();
                check_reset();
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    nd += int'(bus.done);
                end
                chk("abort_no_done", nd, 0);
                return;
            end
            if (bus.done) break;
        end
        exp_doa = 8'(-90 + 5 * best_b);
        chk("done_cycle", k, 371);
        chk("busy_at_done", bus.busy, 0);
        chk("best_beam", bus.best_beam, best_b);
        chk("best_pwr", bus.best_pwr, best_p);
        chk("doa", $unsigned(bus.doa), exp_doa);
        chk("detect", bus.detect, best_p >= bus.pwr_thresh);
        chk("sb_empty", sb.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("best_beam_held", bus.best_beam, best_b);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.spec_q     = '0;
        bus.pwr_thresh = '0;
        fill_rom(0, 0);
        repeat (3) @(negedge clk);
        check_reset();
        KEY = 4'hF;

        scan(0, 0);

        fill_rom(1, 0);
        rom[20*4] = {14'(3), 14'(0)};
        set_spec(0, 100, 0);
        scan(0, 0);

        bus.pwr_thresh = 65'd100000;
        scan(100, 0);

        bus.pwr_thresh = '0;
        fill_rom(1, 0);
        rom[5*4] = {14'(3), 14'(0)};
        rom[9*4] = {14'(0), 14'(3)};
        scan(0, 0);

        for (int m = 0; m < 4; m++) set_spec(m, -8192, -8192);
        fill_rom(-8192, 8191);
        scan(0, 0);

        bus.spec_q = '0;
        set_spec(0, 100, 0);
        fill_rom(1, 0);
        rom[20*4] = {14'(3), 14'(0)};
        scan(0, 150);
        scan(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
